// File: rtl/mod_add_sub_serial_pkg.sv
// Shared definitions for the limb-serial modular adder/subtractor:
// FSM encoding and limb-count helpers.
package mod_add_sub_serial_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int DEF_NBITS  = 2048;
  localparam int DEF_LIMB   = 64;
  localparam int DEF_NLIMBS = DEF_NBITS / DEF_LIMB;

  function automatic int idx_width(input int nlimbs);
    return (nlimbs > 1) ? $clog2(nlimbs) : 1;
  endfunction

  // Index of the last limb to process; nbits == 0 selects the full width.
  function automatic int last_limb_idx(input int nbits, input int limb, input int nlimbs);
    if (nbits == 0) return nlimbs - 1;
    return (nbits + limb - 1) / limb - 1;
  endfunction

endpackage

// File: rtl/mod_add_sub_serial_if.sv
// Command/result bundle of the modular add/sub engine.
interface mod_add_sub_serial_if #(
  parameter int NBITS   = 2048,
  parameter int NBITS_W = $clog2(NBITS) + 1
);
  logic               exec_p;
  logic               sub;
  logic [NBITS_W-1:0] nbits;
  logic [NBITS-1:0]   a;
  logic [NBITS-1:0]   b;
  logic [NBITS-1:0]   m;
  logic [NBITS-1:0]   y;
  logic               busy;
  logic               done_irq_p;

  modport master (output exec_p, sub, nbits, a, b, m, input y, busy, done_irq_p);
  modport slave  (input exec_p, sub, nbits, a, b, m, output y, busy, done_irq_p);
endinterface

// File: rtl/mod_add_sub_limb.sv
// One LIMB-wide stage: raw sum/difference s_i plus its corrected twin t_i
// (s - m for add, s + m for sub), each with its own carry/borrow chain.
module mod_add_sub_limb #(
  parameter int LIMB = 64
) (
  input  logic            sub,
  input  logic [LIMB-1:0] a_i,
  input  logic [LIMB-1:0] b_i,
  input  logic [LIMB-1:0] m_i,
  input  logic            c1_i,
  input  logic            bw2_i,
  input  logic            bw1_i,
  input  logic            c2_i,
  output logic [LIMB-1:0] s_i,
  output logic [LIMB-1:0] t_i,
  output logic            c1_o,
  output logic            bw2_o,
  output logic            bw1_o,
  output logic            c2_o
);
  logic [LIMB:0] x, z;

  // Chains not used by the current mode pass through so they stay at zero.
  always_comb begin
    x     = '0;
    z     = '0;
    c1_o  = c1_i;
    bw2_o = bw2_i;
    bw1_o = bw1_i;
    c2_o  = c2_i;
    if (!sub) begin
      x     = {1'b0, a_i} + {1'b0, b_i} + {{LIMB{1'b0}}, c1_i};
      z     = {1'b0, x[LIMB-1:0]} - {1'b0, m_i} - {{LIMB{1'b0}}, bw2_i};
      c1_o  = x[LIMB];
      bw2_o = z[LIMB];
    end else begin
      x     = {1'b0, a_i} - {1'b0, b_i} - {{LIMB{1'b0}}, bw1_i};
      z     = {1'b0, x[LIMB-1:0]} + {1'b0, m_i} + {{LIMB{1'b0}}, c2_i};
      bw1_o = x[LIMB];
      c2_o  = z[LIMB];
    end
    s_i = x[LIMB-1:0];
    t_i = z[LIMB-1:0];
  end
endmodule

// File: rtl/mod_add_sub_serial.sv
// Limb-serial y = (a +/- b) mod m with exec_p/done_irq_p handshake;
// latency L+1 cycles, L = active limb count.
module mod_add_sub_serial
  import mod_add_sub_serial_pkg::*;
#(
  parameter int NBITS   = 2048,
  parameter int LIMB    = 64,
  parameter int NBITS_W = $clog2(NBITS) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  mod_add_sub_serial_if.slave bus
);
  localparam int NLIMBS = NBITS / LIMB;
  localparam int IDX_W  = idx_width(NLIMBS);

  typedef logic [NLIMBS-1:0][LIMB-1:0] limbs_t;

  state_t           state, state_nx;
  limbs_t           a_r, b_r, m_r, s_reg, t_reg;
  logic             sub_r;
  logic [IDX_W-1:0] idx, last;
  logic             c1, bw2, bw1, c2;
  logic [LIMB-1:0]  s_i, t_i;
  logic             c1_o, bw2_o, bw1_o, c2_o;
  logic             start, take_t;

  // The completion-pulse cycle already reads as IDLE, so exec_p is masked there.
  assign start  = (state == S_IDLE) && bus.exec_p && !bus.done_irq_p;
  assign take_t = sub_r ? bw1 : (c1 || !bw2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (idx == last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  mod_add_sub_limb #(.LIMB(LIMB)) u_limb (
    .sub   (sub_r),
    .a_i   (a_r[idx]),
    .b_i   (b_r[idx]),
    .m_i   (m_r[idx]),
    .c1_i  (c1),
    .bw2_i (bw2),
    .bw1_i (bw1),
    .c2_i  (c2),
    .s_i   (s_i),
    .t_i   (t_i),
    .c1_o  (c1_o),
    .bw2_o (bw2_o),
    .bw1_o (bw1_o),
    .c2_o  (c2_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r            <= '0;
      b_r            <= '0;
      m_r            <= '0;
      s_reg          <= '0;
      t_reg          <= '0;
      sub_r          <= 1'b0;
      idx            <= '0;
      last           <= '0;
      {c1, bw2}      <= 2'b00;
      {bw1, c2}      <= 2'b00;
      bus.y          <= '0;
      bus.busy       <= 1'b0;
      bus.done_irq_p <= 1'b0;
    end else begin
      bus.done_irq_p <= 1'b0;
      if (bus.done_irq_p) bus.busy <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          a_r       <= bus.a;
          b_r       <= bus.b;
          m_r       <= bus.m;
          sub_r     <= bus.sub;
          last      <= IDX_W'(last_limb_idx(int'(bus.nbits), LIMB, NLIMBS));
          idx       <= '0;
          s_reg     <= '0;
          t_reg     <= '0;
          {c1, bw2} <= 2'b00;
          {bw1, c2} <= 2'b00;
          bus.busy  <= 1'b1;
        end
        S_RUN: begin
          s_reg[idx] <= s_i;
          t_reg[idx] <= t_i;
          idx        <= idx + 1'b1;
          c1         <= c1_o;
          bw2        <= bw2_o;
          bw1        <= bw1_o;
          c2         <= c2_o;
        end
        S_DONE: begin
          bus.y          <= take_t ? t_reg : s_reg;
          bus.done_irq_p <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_add_sub_serial.sv
// Scoreboard bench for mod_add_sub_serial at NBITS=256, LIMB=64.
module tb_mod_add_sub_serial;
  localparam int NBITS   = 256;
  localparam int LIMB    = 64;
  localparam int NBITS_W = $clog2(NBITS) + 1;

  typedef logic [NBITS-1:0] word_t;
  typedef struct {
    word_t y;
    int    cyc;
    string name;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  word_t p25519, m64, m65;

  always #5 clk = ~clk;

  mod_add_sub_serial_if #(.NBITS(NBITS), .NBITS_W(NBITS_W)) bus ();

  mod_add_sub_serial #(.NBITS(NBITS), .LIMB(LIMB), .NBITS_W(NBITS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done_irq_p must match the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (bus.done_irq_p === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done_irq_p at cycle %0d with no operation pending", cyc);
      end else begin
        e = q.pop_front();
        chk({e.name, "_y"}, bus.y, e.y);
        chk({e.name, "_latency"}, word_t'(cyc), word_t'(e.cyc));
        chk({e.name, "_busy_in_done"}, word_t'(bus.busy), word_t'(1));
      end
    end
  end

  // Drive one start pulse; operands are scrambled right after to prove latching.
  task automatic issue(input string nm, input word_t a, input word_t b, input word_t m,
                       input logic s, input int nb, input int nl, input bit expect_done,
                       input word_t y);
    @(negedge clk);
    bus.a      = a;
    bus.b      = b;
    bus.m      = m;
    bus.sub    = s;
    bus.nbits  = NBITS_W'(nb);
    bus.exec_p = 1'b1;
    if (expect_done) q.push_back('{y, cyc + nl + 2, nm});
    @(negedge clk);
    bus.exec_p = 1'b0;
    bus.a      = '1;
    bus.b      = '1;
    bus.m      = '0;
    bus.sub    = ~s;
    bus.nbits  = '0;
    if (expect_done) chk({nm, "_busy_after_start"}, word_t'(bus.busy), word_t'(1));
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done_irq_p === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: no done_irq_p within 200 cycles, expected one", nm);
  endtask

  initial begin
    p25519     = (word_t'(1) << 255) - word_t'(19);
    m64        = word_t'(64'hFFFF_FFFF_FFFF_FFC5);
    m65        = (word_t'(1) << 64) + word_t'(13);
    bus.exec_p = 1'b0;
    bus.sub    = 1'b0;
    bus.nbits  = '0;
    bus.a      = '0;
    bus.b      = '0;
    bus.m      = '0;

    repeat (3) @(negedge clk);
    chk("reset_y", bus.y, '0);
    chk("reset_busy", word_t'(bus.busy), '0);
    chk("reset_done", word_t'(bus.done_irq_p), '0);
    rst_n = 1'b1;

    issue("add_wrap", p25519 - 1, 1, p25519, 1'b0, 256, 4, 1'b1, '0);
    wait_done("add_wrap");
    issue("sub_underflow", 0, 1, p25519, 1'b1, 256, 4, 1'b1, p25519 - 1);
    wait_done("sub_underflow");
    // Issued in the first IDLE cycle after the pulse.
    issue("sub_b2b", 5, 3, p25519, 1'b1, 256, 4, 1'b1, 2);
    wait_done("sub_b2b");

    // Start pulse coinciding with done_irq_p must be dropped.
    bus.a = 9; bus.b = 9; bus.m = p25519; bus.sub = 1'b0; bus.nbits = '0;
    bus.exec_p = 1'b1;
    @(negedge clk);
    bus.exec_p = 1'b0;
    chk("exec_on_done_ignored", word_t'(bus.busy), '0);

    issue("short64", m64 - 2, 7, m64, 1'b0, 64, 1, 1'b1, 5);
    wait_done("short64");
    issue("short65", m65 - 3, 5, m65, 1'b0, 65, 2, 1'b1, 2);
    wait_done("short65");
    issue("carry_full_nb0", (word_t'(1) << 64) - 1, 1, p25519, 1'b0, 0, 4, 1'b1,
          word_t'(1) << 64);
    wait_done("carry_full_nb0");

    // Second pulse during RUN is ignored: only one completion, first result.
    issue("repulse", 10, 20, p25519, 1'b0, 256, 4, 1'b1, 30);
    bus.a = 100; bus.b = 200; bus.m = p25519; bus.sub = 1'b1; bus.nbits = '0;
    bus.exec_p = 1'b1;
    @(negedge clk);
    bus.exec_p = 1'b0;
    wait_done("repulse");
    repeat (8) @(negedge clk);

    // Reset in the second RUN cycle aborts silently.
    issue("aborted", 1, 2, p25519, 1'b0, 256, 4, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_y", bus.y, '0);
    chk("abort_busy", word_t'(bus.busy), '0);
    chk("abort_done", word_t'(bus.done_irq_p), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    issue("after_reset", 7, 9, p25519, 1'b1, 256, 4, 1'b1, p25519 - 2);
    wait_done("after_reset");
    repeat (3) @(negedge clk);
    chk("pending_left", word_t'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
